vending_session_ctrl: RTL
=========================

# vending_session_ctrl

Transaction controller for the vending machine. Accepts coins, latches a product selection, and checks accumulated credit against the selected price. When credit covers the price it issues a request/acknowledge handshake to the dispenser, then returns change as unit pulses; an inactivity timeout or a cancel refunds all credit. It sits between the coin acceptor and selection panel on one side and the dispenser and change hopper on the other.

## Interface
- CREDIT_W, 7, credit register width
- MAX_CREDIT, 60, highest credit accepted; coins that would exceed it are rejected
- PRICE0..PRICE3, 15/20/25/30, product prices; each must be a nonzero multiple of 5 and ≤ MAX_CREDIT
- TIMEOUT_CYC, 6144, inactivity cycles in COLLECT before auto-refund
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- coin  in  2  coin code sampled every edge: 00 none, 01 five units, 10 ten units, 11 invalid
- sel_valid  in  1  selection strobe
- sel_id  in  2  product index, used when sel_valid=1
- cancel  in  1  refund request
- disp_ack  in  1  dispenser done
- disp_req  out  1  dispense request
- disp_id  out  2  latched product index
- vend_done  out  1  one-cycle pulse when a product is delivered
- chg_pulse  out  1  one pulse per 5 units returned
- coin_reject  out  1  one-cycle pulse when a coin is not credited
- credit  out  CREDIT_W  current credit
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, COLLECT, DISPENSE, CHANGE.
- IDLE: credit=0, no selection held.
  - A valid coin goes to COLLECT with credit = coin value.
  - sel_valid latches sel_id and goes to COLLECT.
- COLLECT:
  - Each edge with coin 01/10 adds 5/10 if the result is ≤ MAX_CREDIT; otherwise coin_reject pulses and credit is unchanged.
  - Coin 11 always pulses coin_reject.
  - A new sel_valid overwrites the latched selection.
  - When a selection is latched and registered credit ≥ its price, go to DISPENSE.
  - cancel goes to CHANGE. With credit 0, cancel goes to IDLE.
  - Timeout: the counter clears on any coin code ≠ 00 or on sel_valid and increments otherwise. Reaching TIMEOUT_CYC goes to CHANGE, or to IDLE if credit is 0.
- DISPENSE:
  - disp_req=1 and disp_id holds steady until disp_ack.
  - On the disp_ack edge: credit -= price, vend_done pulses, selection clears.
  - Next state is CHANGE if the remainder is > 0, else IDLE.
  - cancel is ignored. All coins are rejected (coin_reject pulses).
- CHANGE:
  - chg_pulse alternates 1,0. Each high cycle decrements credit by 5.
  - When credit reaches 0, go to IDLE.
  - Coins are rejected; cancel and sel_valid are ignored.
- Arithmetic is unsigned CREDIT_W-bit. Credit never exceeds MAX_CREDIT and never underflows.
- Priority in COLLECT on a single edge: timeout/cancel > dispense check > coin add. A coin arriving on the edge that leaves COLLECT is rejected.

## Timing
- Reset (async assert, sync-released use): state IDLE; all outputs 0; credit 0; timeout counter 0; selection cleared.
- Reset mid-DISPENSE or mid-CHANGE drops disp_req and chg_pulse immediately. Credit is lost; this is accepted.
- Coin-to-credit latency: 1 edge.
- Sufficient credit to disp_req: 1 edge, since disp_req is decoded from the state register (Moore).
- disp_ack to vend_done: same edge (registered pulse, visible the next cycle). disp_ack outside DISPENSE is ignored.
- Change rate: one pulse per 2 cycles. The first pulse comes in the first CHANGE cycle.
- vend_done, coin_reject and chg_pulse are exactly 1 cycle wide.

## Structure
- Package vending_pkg holds:
  - coin code constants (COIN_NONE, COIN_5, COIN_10, COIN_BAD)
  - coin values
  - the state enum
  - the refund unit (5)
- Sub-module vending_timeout: a counter with clear/enable inputs and a terminal-count output, parameterised by TIMEOUT_CYC.
- Price lookup is a 4-way mux inside the controller.

## Test plan
- Select product 0 (15). Coins 10 then 01: credit 10 then 15, disp_req=1, disp_id=0. disp_ack after 3 cycles produces a vend_done pulse, credit 0, IDLE, and no chg_pulse.
- Select product 0. Coins 10, 10: credit 20, dispense. After ack, credit 5, one chg_pulse, then IDLE.
- No selection. Coin 10 seven times: the first six credit up to 60; the seventh pulses coin_reject and credit stays 60. Coin 11 also pulses coin_reject.
- Coin 10 then idle for TIMEOUT_CYC cycles: CHANGE, two chg_pulses, IDLE, busy=0. A coin at cycle TIMEOUT_CYC−1 restarts the count.
- Credit 15 and cancel in COLLECT: three chg_pulses. cancel while disp_req=1 is ignored, and the dispense completes on ack.
- Reset asserted in DISPENSE with credit 25: disp_req, credit and busy go to 0 immediately, and the next sel_valid starts a fresh session.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared coin codes, coin values, refund unit and session state encoding for the vending controller.
package vending_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  localparam int unsigned COIN_5_VAL  = 5;
  localparam int unsigned COIN_10_VAL = 10;
  localparam int unsigned REFUND_UNIT = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  function automatic int unsigned coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  return COIN_5_VAL;
      COIN_10: return COIN_10_VAL;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/vending_timeout.sv
// Inactivity counter: o_tc is combinational on the enabled edge that would reach TIMEOUT_CYC.
// Clear dominates; the count restarts from zero after terminal count.
module vending_timeout #(
  parameter int unsigned TIMEOUT_CYC = 6144
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tc = i_en && !i_clr && (r_cnt == LAST_CNT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_tc) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vending_session_ctrl.sv
// Vending session FSM: credits coins, latches a selection, runs the dispenser handshake, pays change.
// Coin-to-credit 1 cycle; disp_req held until disp_ack; coins refused outside IDLE/COLLECT.
module vending_session_ctrl #(
  parameter int unsigned CREDIT_W    = 7,
  parameter int unsigned MAX_CREDIT  = 60,
  parameter int unsigned PRICE0      = 15,
  parameter int unsigned PRICE1      = 20,
  parameter int unsigned PRICE2      = 25,
  parameter int unsigned PRICE3      = 30,
  parameter int unsigned TIMEOUT_CYC = 6144
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                sel_valid,
  input  logic [1:0]          sel_id,
  input  logic                cancel,
  input  logic                disp_ack,
  output logic                disp_req,
  output logic [1:0]          disp_id,
  output logic                vend_done,
  output logic                chg_pulse,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  import vending_pkg::*;

  localparam logic [CREDIT_W-1:0] PRICE0_C = CREDIT_W'(PRICE0);
  localparam logic [CREDIT_W-1:0] PRICE1_C = CREDIT_W'(PRICE1);
  localparam logic [CREDIT_W-1:0] PRICE2_C = CREDIT_W'(PRICE2);
  localparam logic [CREDIT_W-1:0] PRICE3_C = CREDIT_W'(PRICE3);
  localparam logic [CREDIT_W-1:0] REFUND_C = CREDIT_W'(REFUND_UNIT);
  localparam logic [CREDIT_W:0]   MAX_C    = (CREDIT_W+1)'(MAX_CREDIT);

  state_t              r_state,       w_state_nxt;
  logic [CREDIT_W-1:0] r_credit,      w_credit_nxt;
  logic                r_sel_vld,     w_sel_vld_nxt;
  logic [1:0]          r_sel_id,      w_sel_id_nxt;
  logic                r_chg_phase,   w_chg_phase_nxt;
  logic                r_vend_done,   w_vend_done_nxt;
  logic                r_coin_reject, w_coin_reject_nxt;

  logic [CREDIT_W-1:0] w_price;
  logic [CREDIT_W-1:0] w_coin_val;
  logic [CREDIT_W:0]   w_coin_sum;
  logic                w_coin_present;
  logic                w_coin_valid;
  logic                w_coin_ok;
  logic                w_can_vend;
  logic [CREDIT_W-1:0] w_vend_left;
  logic [CREDIT_W-1:0] w_refund_left;
  logic                w_to_clr;
  logic                w_to_en;
  logic                w_to_tc;

  always_comb begin
    case (r_sel_id)
      2'd0:    w_price = PRICE0_C;
      2'd1:    w_price = PRICE1_C;
      2'd2:    w_price = PRICE2_C;
      default: w_price = PRICE3_C;
    endcase
  end

  assign w_coin_val     = CREDIT_W'(coin_value(coin));
  assign w_coin_sum     = {1'b0, r_credit} + {1'b0, w_coin_val};
  assign w_coin_present = (coin != COIN_NONE);
  assign w_coin_valid   = (coin == COIN_5) || (coin == COIN_10);
  assign w_coin_ok      = w_coin_valid && (w_coin_sum <= MAX_C);
  assign w_can_vend     = r_sel_vld && (r_credit >= w_price);
  assign w_vend_left    = (r_credit >= w_price)  ? (r_credit - w_price)  : '0;
  assign w_refund_left  = (r_credit >= REFUND_C) ? (r_credit - REFUND_C) : '0;

  // Any coin activity or selection counts as user activity and restarts the inactivity window.
  assign w_to_en  = (r_state == COLLECT);
  assign w_to_clr = !w_to_en || w_coin_present || sel_valid;

  vending_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (w_to_clr),
    .i_en    (w_to_en),
    .o_tc    (w_to_tc)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_credit_nxt      = r_credit;
    w_sel_vld_nxt     = r_sel_vld;
    w_sel_id_nxt      = r_sel_id;
    w_chg_phase_nxt   = 1'b0;
    w_vend_done_nxt   = 1'b0;
    w_coin_reject_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_coin_valid) begin
          w_credit_nxt = w_coin_val;
          w_state_nxt  = COLLECT;
        end else if (w_coin_present) begin
          w_coin_reject_nxt = 1'b1;
        end
        if (sel_valid) begin
          w_sel_vld_nxt = 1'b1;
          w_sel_id_nxt  = sel_id;
          w_state_nxt   = COLLECT;
        end
      end

      COLLECT: begin
        if (w_to_tc || cancel) begin
          w_state_nxt       = (r_credit == '0) ? IDLE : CHANGE;
          w_sel_vld_nxt     = 1'b0;
          w_sel_id_nxt      = '0;
          w_coin_reject_nxt = w_coin_present;
        end else if (w_can_vend) begin
          // Selection is frozen on this edge so disp_id matches the price just checked.
          w_state_nxt       = DISPENSE;
          w_coin_reject_nxt = w_coin_present;
        end else begin
          if (w_coin_ok) begin
            w_credit_nxt = w_coin_sum[CREDIT_W-1:0];
          end else if (w_coin_present) begin
            w_coin_reject_nxt = 1'b1;
          end
          if (sel_valid) begin
            w_sel_vld_nxt = 1'b1;
            w_sel_id_nxt  = sel_id;
          end
        end
      end

      DISPENSE: begin
        w_coin_reject_nxt = w_coin_present;
        if (disp_ack) begin
          w_credit_nxt    = w_vend_left;
          w_vend_done_nxt = 1'b1;
          w_sel_vld_nxt   = 1'b0;
          w_sel_id_nxt    = '0;
          w_state_nxt     = (w_vend_left == '0) ? IDLE : CHANGE;
        end
      end

      CHANGE: begin
        w_coin_reject_nxt = w_coin_present;
        if (!r_chg_phase) begin
          w_credit_nxt    = w_refund_left;
          w_chg_phase_nxt = (w_refund_left != '0);
          if (w_refund_left == '0) begin
            w_state_nxt = IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_credit      <= '0;
      r_sel_vld     <= 1'b0;
      r_sel_id      <= '0;
      r_chg_phase   <= 1'b0;
      r_vend_done   <= 1'b0;
      r_coin_reject <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_credit      <= w_credit_nxt;
      r_sel_vld     <= w_sel_vld_nxt;
      r_sel_id      <= w_sel_id_nxt;
      r_chg_phase   <= w_chg_phase_nxt;
      r_vend_done   <= w_vend_done_nxt;
      r_coin_reject <= w_coin_reject_nxt;
    end
  end

  assign disp_req    = (r_state == DISPENSE);
  assign disp_id     = r_sel_id;
  assign chg_pulse   = (r_state == CHANGE) && !r_chg_phase;
  assign busy        = (r_state != IDLE);
  assign credit      = r_credit;
  assign vend_done   = r_vend_done;
  assign coin_reject = r_coin_reject;

endmodule
